systolic_drain_ctrl: RTL and testbench

//  Sequencer for the NxN output-stationary systolic PE array; sits directly upstream of the C-buffer write controller.
//  On a start command it runs the MAC phase (K feed cycles plus a skew flush), then drains the accumulators one row per cycle.

---
 rtl/systolic_drain_ctrl_if.sv | 38 +++
 rtl/systolic_drain_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_systolic_drain_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_drain_ctrl_if.sv
// Command, operand-feed and C-buffer row signals between the PE-array sequencer
// and its neighbours.
interface systolic_drain_ctrl_if #(
    parameter int N     = 4,
    parameter int ACC_W = 32,
    parameter int K_W   = 16
) ();
    logic                   cmd_valid;
    logic [2:0]             funct;
    logic [31:0]            input0;
    logic [N*N*ACC_W-1:0]   acc_flat;

    logic [K_W-1:0]         ab_idx;
    logic                   feed_valid;
    logic                   pe_en;
    logic                   pe_clear;
    logic                   C_in_signal;
    logic [3:0]             count;
    logic [N*ACC_W-1:0]     C_row_data;
    logic                   busy;
    logic                   done;
    logic [2:0]             state_dbg;

    // cmd_valid is a single-cycle strobe with no ready: funct/input0 are consumed
    // on every edge where cmd_valid=1. C_in_signal is likewise a strobe with no
    // back-pressure: the writer takes C_row_data/count on every cycle it is high.
    modport slave (
        input  cmd_valid, funct, input0, acc_flat,
        output ab_idx, feed_valid, pe_en, pe_clear, C_in_signal, count,
               C_row_data, busy, done, state_dbg
    );

    modport master (
        output cmd_valid, funct, input0, acc_flat,
        input  ab_idx, feed_valid, pe_en, pe_clear, C_in_signal, count,
               C_row_data, busy, done, state_dbg
    );
endinterface

// File: rtl/systolic_drain_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: feeds K operand columns,
// flushes the skew, drains one accumulator row per cycle, then clears the array.
module systolic_drain_ctrl #(
    parameter int N     = 4,
    parameter int ACC_W = 32,
    parameter int K_W   = 16
) (
    input logic              clk,
    input logic              rst_n,
    systolic_drain_ctrl_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FEED  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Wide enough for the 2N-3 flush terminal at the largest legal N.
    localparam int PH_W       = 5;
    localparam int FLUSH_LAST = 2 * N - 3;
    localparam int DRAIN_LAST = N - 1;
    localparam int ROW_W      = N * ACC_W;

    logic [2:0]       state;
    logic [K_W-1:0]   k_lat;
    logic [K_W-1:0]   feed_cnt;
    logic [PH_W-1:0]  ph_cnt;

    logic [K_W-1:0]   ab_idx_q;
    logic             feed_valid_q;
    logic             pe_en_q;
    logic             pe_clear_q;
    logic             c_in_q;
    logic [3:0]       count_q;
    logic [ROW_W-1:0] row_q;
    logic             busy_q;
    logic             done_q;

    logic             is_start;
    logic             is_abort;
    logic [K_W-1:0]   cmd_k;
    logic [K_W-1:0]   k_last;
    logic [ROW_W-1:0] row_sel;
    logic             unused_bits;

    assign is_start    = bus.cmd_valid && (bus.funct == 3'd2);
    assign is_abort    = bus.cmd_valid && (bus.funct == 3'd1);
    assign cmd_k       = bus.input0[K_W-1:0];
    assign k_last      = k_lat - K_W'(1);
    assign unused_bits = ^bus.input0;

    always_comb begin
        row_sel = '0;
        for (int r = 0; r < N; r++) begin
            if (ph_cnt == PH_W'(r)) row_sel = bus.acc_flat[r*ROW_W +: ROW_W];
        end
    end

    // Control FSM. Abort overrides every transition, including a pending start.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            k_lat    <= '0;
            feed_cnt <= '0;
            ph_cnt   <= '0;
        end else if (is_abort) begin
            state    <= ST_IDLE;
            feed_cnt <= '0;
            ph_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_start) begin
                        k_lat    <= cmd_k;
                        feed_cnt <= '0;
                        ph_cnt   <= '0;
                        // K=0 leaves nothing to accumulate; the array already holds zeros.
                        state    <= (cmd_k == '0) ? ST_DRAIN : ST_FEED;
                    end
                end
                ST_FEED: begin
                    // Compare against K-1 so K = 2^K_W-1 finishes without wrapping.
                    if (feed_cnt == k_last) begin
                        state  <= ST_FLUSH;
                        ph_cnt <= '0;
                    end else begin
                        feed_cnt <= feed_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (ph_cnt == PH_W'(FLUSH_LAST)) begin
                        state  <= ST_DRAIN;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ph_cnt == PH_W'(DRAIN_LAST)) begin
                        state  <= ST_GAP;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs decode the phase the FSM is in, so each phase shows up
    // one cycle after the edge that entered it. Abort is applied directly so the
    // cycle after an abort is already quiet.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ab_idx_q     <= '0;
            feed_valid_q <= 1'b0;
            pe_en_q      <= 1'b0;
            pe_clear_q   <= 1'b0;
            c_in_q       <= 1'b0;
            count_q      <= 4'd0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (is_abort) begin
            ab_idx_q     <= '0;
            feed_valid_q <= 1'b0;
            pe_en_q      <= 1'b0;
            pe_clear_q   <= 1'b1;
            c_in_q       <= 1'b0;
            count_q      <= 4'd0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ab_idx_q     <= '0;
            feed_valid_q <= 1'b0;
            pe_en_q      <= 1'b0;
            pe_clear_q   <= 1'b0;
            c_in_q       <= 1'b0;
            count_q      <= 4'd0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            case (state)
                ST_FEED: begin
                    ab_idx_q     <= feed_cnt;
                    feed_valid_q <= 1'b1;
                    pe_en_q      <= 1'b1;
                    busy_q       <= 1'b1;
                end
                ST_FLUSH: begin
                    ab_idx_q <= k_last;
                    pe_en_q  <= 1'b1;
                    busy_q   <= 1'b1;
                end
                ST_DRAIN: begin
                    c_in_q  <= 1'b1;
                    count_q <= ph_cnt[3:0] + 4'd1;
                    row_q   <= row_sel;
                    busy_q  <= 1'b1;
                end
                ST_GAP: begin
                    pe_clear_q <= 1'b1;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ab_idx      = ab_idx_q;
    assign bus.feed_valid  = feed_valid_q;
    assign bus.pe_en       = pe_en_q;
    assign bus.pe_clear    = pe_clear_q;
    assign bus.C_in_signal = c_in_q;
    assign bus.count       = count_q;
    assign bus.C_row_data  = row_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state;

    a_row_count_range: assert property (@(posedge clk) disable iff (rst_n)
        c_in_q |-> (count_q != 4'd0 && count_q <= 4'(N)));
    a_idle_count_zero: assert property (@(posedge clk) disable iff (rst_n)
        !c_in_q |-> (count_q == 4'd0));
    a_done_clears: assert property (@(posedge clk) disable iff (rst_n)
        done_q |-> pe_clear_q);
    a_feed_needs_en: assert property (@(posedge clk) disable iff (rst_n)
        feed_valid_q |-> pe_en_q);

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Directed bench for systolic_drain_ctrl: a schedule-arithmetic model predicts
// every output each cycle, plus hand-computed spot values at key cycles.
module tb_systolic_drain_ctrl;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int K_W   = 16;
  localparam int ROW_W = N * ACC_W;

  typedef logic [ROW_W-1:0] wide_t;

  typedef struct packed {
    logic           ab_chk;
    logic [K_W-1:0] ab;
    logic           fv;
    logic           pe_en;
    logic           pe_clear;
    logic           c_in;
    logic [3:0]     count;
    logic           busy;
    logic           done;
  } exp_t;

  logic clk;
  logic rst_n;

  systolic_drain_ctrl_if #(.N(N), .ACC_W(ACC_W), .K_W(K_W)) bus ();

  systolic_drain_ctrl #(.N(N), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_checks = 0;
  int    n_fail   = 0;
  wide_t exp_q[$];
  exp_t  exp_s;
  logic  model_live = 1'b0;
  int    cyc = 0;
  logic  tile_on = 1'b0;
  int    t0 = 0;
  int    tk = 0;

  task automatic check(input string name, input wide_t act, input wide_t want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- model ----------------
  // Edge d after the start edge: FEED 1..K, FLUSH K+1..K+2N-2 (K>0 only),
  // DRAIN next N edges with count 1..N, then one GAP edge.
  function automatic int drain_base(input int k);
    return (k == 0) ? 0 : k + 2 * N - 2;
  endfunction

  function automatic int last_d(input int k);
    return drain_base(k) + N + 1;
  endfunction

  function automatic exp_t phase_exp(input int d, input int k);
    exp_t e;
    int   d0;
    e  = '0;
    d0 = drain_base(k);
    if (d >= 1 && d <= k) begin
      e.ab_chk = 1'b1; e.ab = K_W'(d - 1); e.fv = 1'b1; e.pe_en = 1'b1; e.busy = 1'b1;
    end else if (k > 0 && d > k && d <= d0) begin
      e.ab_chk = 1'b1; e.ab = K_W'(k - 1); e.pe_en = 1'b1; e.busy = 1'b1;
    end else if (d > d0 && d <= d0 + N) begin
      e.c_in = 1'b1; e.count = 4'(d - d0); e.busy = 1'b1;
    end else if (d == d0 + N + 1) begin
      e.done = 1'b1; e.pe_clear = 1'b1; e.busy = 1'b1;
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_live = 1'b1;
      if (rst_n) begin
        tile_on = 1'b0;
        exp_s = '0;
        exp_s.ab_chk = 1'b1;
        exp_q.delete();
      end else if (bus.cmd_valid && bus.funct == 3'd1) begin
        tile_on = 1'b0;
        exp_s = '0;
        exp_s.ab_chk = 1'b1;
        exp_s.pe_clear = 1'b1;
        exp_q.delete();
      end else if (tile_on && (cyc - t0) <= last_d(tk)) begin
        exp_s = phase_exp(cyc - t0, tk);
      end else begin
        tile_on = 1'b0;
        exp_s = '0;
        if (bus.cmd_valid && bus.funct == 3'd2) begin
          tile_on = 1'b1;
          t0 = cyc;
          tk = int'(bus.input0[K_W-1:0]);
          for (int r = 0; r < N; r++) exp_q.push_back(bus.acc_flat[r*ROW_W +: ROW_W]);
        end
      end
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    wide_t row;
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("busy",       wide_t'(bus.busy),        wide_t'(exp_s.busy));
        check("done",       wide_t'(bus.done),        wide_t'(exp_s.done));
        check("pe_clear",   wide_t'(bus.pe_clear),    wide_t'(exp_s.pe_clear));
        check("pe_en",      wide_t'(bus.pe_en),       wide_t'(exp_s.pe_en));
        check("feed_valid", wide_t'(bus.feed_valid),  wide_t'(exp_s.fv));
        check("c_in",       wide_t'(bus.C_in_signal), wide_t'(exp_s.c_in));
        check("count",      wide_t'(bus.count),       wide_t'(exp_s.count));
        if (exp_s.ab_chk) check("ab_idx", wide_t'(bus.ab_idx), wide_t'(exp_s.ab));
        if (exp_s.c_in) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL row_q: no expected row, got %0h", bus.C_row_data);
          end else begin
            row = exp_q.pop_front();
            check("row_data", bus.C_row_data, row);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.funct     = f;
    bus.input0    = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.funct     = 3'd0;
    bus.input0    = 32'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pattern_a();
    logic [N*N*ACC_W-1:0] acc;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc[(r*N+c)*ACC_W +: ACC_W] = ACC_W'(16 * r + c);
    bus.acc_flat = acc;
  endtask

  task automatic load_random();
    logic [N*N*ACC_W-1:0] acc;
    for (int i = 0; i < N * N; i++) acc[i*ACC_W +: ACC_W] = $urandom_range(32'hFFFF_FFFF, 0);
    bus.acc_flat = acc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.funct     = 3'd2;
    bus.input0    = 32'd8;
    load_pattern_a();

    // Reset holds off a start command.
    cycles(3);
    check("rst_state", wide_t'(bus.state_dbg), wide_t'(3'd0));
    check("rst_busy",  wide_t'(bus.busy),      wide_t'(1'b0));
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.funct     = 3'd0;
    bus.input0    = 32'd0;
    cycles(2);

    // Unused codes and a bare funct=2 without strobe do nothing.
    issue(3'd3, 32'd5);
    issue(3'd0, 32'd5);
    bus.funct = 3'd2;
    cycles(1);
    bus.funct = 3'd0;
    cycles(2);
    check("idle_busy", wide_t'(bus.busy), wide_t'(1'b0));

    // K=8 full tile, then back-to-back K=3.
    issue(3'd2, 32'd8);
    cycles(3);
    check("k8_ab_c3", wide_t'(bus.ab_idx), wide_t'(16'd2));
    cycles(8);
    check("k8_flush_ab", wide_t'(bus.ab_idx), wide_t'(16'd7));
    check("k8_flush_fv", wide_t'(bus.feed_valid), wide_t'(1'b0));
    check("k8_flush_en", wide_t'(bus.pe_en), wide_t'(1'b1));
    cycles(6);
    check("k8_count_c17", wide_t'(bus.count), wide_t'(4'd3));
    check("model_count_c17", wide_t'(exp_s.count), wide_t'(4'd3));
    check("k8_row2", bus.C_row_data, {32'd35, 32'd34, 32'd33, 32'd32});
    cycles(2);
    check("k8_done_c19", wide_t'(bus.done), wide_t'(1'b1));
    check("k8_clr_c19", wide_t'(bus.pe_clear), wide_t'(1'b1));
    issue(3'd2, 32'd3);
    check("b2b_busy_drop", wide_t'(bus.busy), wide_t'(1'b0));
    cycles(1);
    check("b2b_ab0", wide_t'(bus.ab_idx), wide_t'(16'd0));
    check("b2b_fv", wide_t'(bus.feed_valid), wide_t'(1'b1));
    cycles(14);

    // K=0 goes straight to drain.
    load_random();
    issue(3'd2, 32'd0);
    cycles(1);
    check("k0_count_c1", wide_t'(bus.count), wide_t'(4'd1));
    check("k0_pe_en", wide_t'(bus.pe_en), wide_t'(1'b0));
    cycles(4);
    check("k0_done_c5", wide_t'(bus.done), wide_t'(1'b1));
    cycles(2);

    // K=1 boundary.
    issue(3'd2, 32'd1);
    cycles(2);
    check("k1_flush_ab", wide_t'(bus.ab_idx), wide_t'(16'd0));
    check("k1_flush_fv", wide_t'(bus.feed_valid), wide_t'(1'b0));
    cycles(11);

    // Abort mid-drain, then a fresh full tile with a stray code mid-run.
    load_pattern_a();
    issue(3'd2, 32'd2);
    cycles(10);
    check("ab_count2", wide_t'(bus.count), wide_t'(4'd2));
    issue(3'd1, 32'd0);
    check("ab_count0", wide_t'(bus.count), wide_t'(4'd0));
    check("ab_cin", wide_t'(bus.C_in_signal), wide_t'(1'b0));
    check("ab_clear", wide_t'(bus.pe_clear), wide_t'(1'b1));
    check("ab_busy", wide_t'(bus.busy), wide_t'(1'b0));
    check("ab_done", wide_t'(bus.done), wide_t'(1'b0));
    cycles(1);
    check("ab_clear_pulse", wide_t'(bus.pe_clear), wide_t'(1'b0));
    issue(3'd2, 32'd5);
    cycles(2);
    issue(3'd7, 32'd99);
    cycles(13);
    check("k5_done_c16", wide_t'(bus.done), wide_t'(1'b1));
    cycles(1);

    // Start while busy is ignored.
    issue(3'd2, 32'd8);
    cycles(4);
    issue(3'd2, 32'd3);
    cycles(14);
    check("ign_done_c19", wide_t'(bus.done), wide_t'(1'b1));
    cycles(1);
    check("ign_busy_c20", wide_t'(bus.busy), wide_t'(1'b0));
    cycles(5);

    // Abort during FEED.
    issue(3'd2, 32'd6);
    cycles(2);
    issue(3'd1, 32'd0);
    check("abf_ab_idx", wide_t'(bus.ab_idx), wide_t'(16'd0));
    check("abf_pe_en", wide_t'(bus.pe_en), wide_t'(1'b0));
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
